// File: rtl/core_fetch_pkg.sv
// core_fetch_pkg: shared definitions for the instruction-fetch / PC stage.
//   FETCH_ST_BIT      width of the fetch FSM state encoding
//   fetch_st_e        FSM states IDLE, FETCH, HOLD, HALTED
//   RESET_PC_DEFAULT  default architectural reset PC (word-aligned)
//   is_word_aligned   true when a byte address has its two low bits clear
package core_fetch_pkg;

  localparam int FETCH_ST_BIT = 2;

  typedef enum logic [FETCH_ST_BIT-1:0] {
    FETCH_ST_IDLE   = 2'd0,
    FETCH_ST_FETCH  = 2'd1,
    FETCH_ST_HOLD   = 2'd2,
    FETCH_ST_HALTED = 2'd3
  } fetch_st_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/core_fetch_if.sv
// core_fetch_if: instruction-memory port plus decode handshake of core_fetch.
//   imem_req/imem_addr  fetch request towards instruction memory
//   imem_ack/imem_data  memory response (data valid when ack is high)
//   inst/inst_valid     instruction presented to decode
//   inst_ready          decode consumes inst (the commit)
// master = fetch stage, slave = memory/decode side.
interface core_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst, inst_valid,
    input  imem_ack, imem_data, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_valid,
    output imem_ack, imem_data, inst_ready
  );
endinterface

// File: rtl/core_fetch_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping.
//   clk    clock, rst_n  asynchronous active-low reset (clears to 0)
//   inc    add one this cycle (ignored once saturated)
//   q      registered count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Count register; holds at all-ones once reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else if (inc && (q_r != {W{1'b1}})) begin
      q_r <= q_r + W'(1);
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/core_fetch.sv
// core_fetch: instruction-fetch and program-counter stage.
//   clk, rst_n        clock / asynchronous active-low reset
//   en                run enable (gates leaving IDLE and the commit)
//   halt              stop after this commit (sampled at commit only)
//   pc_new, branched, is_jump  where-to-go results, sampled at commit only
//   bus               imem req/ack port and decode valid/ready handshake
//   pc, pc_4          current PC and pc+4 (combinational, wraps)
//   halted, misalign  stopped / stopped because pc_new was misaligned
//   cnt_*             saturating performance counters
module core_fetch
  import core_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             halt,
  input  logic [31:0]      pc_new,
  input  logic             branched,
  input  logic             is_jump,
  core_fetch_if.master     bus,
  output logic [31:0]      pc,
  output logic [31:0]      pc_4,
  output logic             halted,
  output logic             misalign,
  output logic [CNT_W-1:0] cnt_cycle,
  output logic [CNT_W-1:0] cnt_inst,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_jump
);

  fetch_st_e   state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] inst_r, inst_s;
  logic        misalign_r, misalign_s;
  logic        req_r, valid_r, halted_r;
  logic        commit_s;
  logic        busy_s;

  // Next-state, next-PC and capture logic of the fetch FSM.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    inst_s     = inst_r;
    misalign_s = misalign_r;
    commit_s   = 1'b0;
    case (state_r)
      FETCH_ST_IDLE: begin
        if (en) state_s = FETCH_ST_FETCH;
        else    state_s = FETCH_ST_IDLE;
      end
      // Request stays up until ack even if en drops meanwhile.
      FETCH_ST_FETCH: begin
        if (bus.imem_ack) begin
          inst_s  = bus.imem_data;
          state_s = FETCH_ST_HOLD;
        end else begin
          state_s = FETCH_ST_FETCH;
        end
      end
      // Misaligned target wins over halt and leaves pc untouched.
      FETCH_ST_HOLD: begin
        if (bus.inst_ready && en) begin
          commit_s = 1'b1;
          if (!is_word_aligned(pc_new)) begin
            misalign_s = 1'b1;
            state_s    = FETCH_ST_HALTED;
          end else begin
            pc_s = pc_new;
            if (halt) state_s = FETCH_ST_HALTED;
            else      state_s = FETCH_ST_FETCH;
          end
        end else begin
          state_s = FETCH_ST_HOLD;
        end
      end
      FETCH_ST_HALTED: state_s = FETCH_ST_HALTED;
      default:         state_s = FETCH_ST_IDLE;
    endcase
  end

  // State, PC, instruction and registered status outputs (decoded from next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= FETCH_ST_IDLE;
      pc_r       <= RESET_PC;
      inst_r     <= 32'h0000_0000;
      misalign_r <= 1'b0;
      req_r      <= 1'b0;
      valid_r    <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      inst_r     <= inst_s;
      misalign_r <= misalign_s;
      req_r      <= (state_s == FETCH_ST_FETCH);
      valid_r    <= (state_s == FETCH_ST_HOLD);
      halted_r   <= (state_s == FETCH_ST_HALTED);
    end
  end

  assign busy_s = (state_r == FETCH_ST_FETCH) || (state_r == FETCH_ST_HOLD);

  sat_counter #(.W(CNT_W)) u_cnt_cycle (
    .clk(clk), .rst_n(rst_n), .inc(busy_s), .q(cnt_cycle)
  );
  sat_counter #(.W(CNT_W)) u_cnt_inst (
    .clk(clk), .rst_n(rst_n), .inc(commit_s), .q(cnt_inst)
  );
  sat_counter #(.W(CNT_W)) u_cnt_branch (
    .clk(clk), .rst_n(rst_n), .inc(commit_s & branched), .q(cnt_branch)
  );
  sat_counter #(.W(CNT_W)) u_cnt_jump (
    .clk(clk), .rst_n(rst_n), .inc(commit_s & is_jump), .q(cnt_jump)
  );

  assign bus.imem_req   = req_r;
  assign bus.imem_addr  = pc_r;
  assign bus.inst       = inst_r;
  assign bus.inst_valid = valid_r;
  assign pc             = pc_r;
  assign pc_4           = pc_r + 32'd4;
  assign halted         = halted_r;
  assign misalign       = misalign_r;

endmodule

// File: tb/tb_core_fetch.sv
// tb_core_fetch: directed bench for core_fetch. Stimulus pushes the expected
// {pc, inst} of every commit into a queue; a negedge monitor pops and compares
// at each commit. A second instance (RESET_PC = 0xFFFF_FFFC, CNT_W = 4) covers
// pc_4 wrap and counter saturation.
module tb_core_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, halt, branched, is_jump;
  logic [31:0] pc_new, pc, pc_4;
  logic        halted, misalign;
  logic [31:0] cnt_cycle, cnt_inst, cnt_branch, cnt_jump;

  logic        en2, halt2, branched2, is_jump2;
  logic [31:0] pc_new2, pc2, pc_42;
  logic        halted2, misalign2;
  logic [3:0]  cnt_cycle2, cnt_inst2, cnt_branch2, cnt_jump2;

  core_fetch_if bus();
  core_fetch_if bus2();

  core_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .halt(halt), .pc_new(pc_new),
    .branched(branched), .is_jump(is_jump), .bus(bus), .pc(pc), .pc_4(pc_4),
    .halted(halted), .misalign(misalign), .cnt_cycle(cnt_cycle),
    .cnt_inst(cnt_inst), .cnt_branch(cnt_branch), .cnt_jump(cnt_jump)
  );

  core_fetch #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .halt(halt2), .pc_new(pc_new2),
    .branched(branched2), .is_jump(is_jump2), .bus(bus2), .pc(pc2), .pc_4(pc_42),
    .halted(halted2), .misalign(misalign2), .cnt_cycle(cnt_cycle2),
    .cnt_inst(cnt_inst2), .cnt_branch(cnt_branch2), .cnt_jump(cnt_jump2)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every commit must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.inst_valid && bus.inst_ready && en) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_commit: got pc %h expected none", pc);
      end else begin
        mon_e = sb_q.pop_front();
        check32("commit_pc", pc, mon_e.pc);
        check32("commit_inst", bus.inst, mon_e.inst);
      end
    end
  end

  // One full instruction on the main instance: fetch, optional delay/stall, commit.
  task automatic do_inst(input logic [31:0] data, input logic [31:0] exp_pc, input int dly,
                         input logic en_toggle, input logic stall, input logic [31:0] npc,
                         input logic br, input logic jmp, input logic hlt);
    int n;
    logic [31:0] ci;
    n = 0;
    while (!bus.imem_req && n < 50) begin @(posedge clk); #1; n++; end
    check32("req_seen", {31'd0, bus.imem_req}, 32'd1);
    check32("fetch_addr", bus.imem_addr, exp_pc);
    sb_q.push_back({exp_pc, data});
    for (int i = 0; i < dly; i++) begin
      if (en_toggle) en = (i % 2 == 1) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      check32("req_held", {31'd0, bus.imem_req}, 32'd1);
      check32("addr_held", bus.imem_addr, exp_pc);
    end
    en = 1'b1;
    bus.imem_ack = 1'b1; bus.imem_data = data;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0; bus.imem_data = 32'hDEAD_BEEF;
    n = 0;
    while (!bus.inst_valid && n < 50) begin @(posedge clk); #1; n++; end
    check32("valid_seen", {31'd0, bus.inst_valid}, 32'd1);
    check32("inst_capture", bus.inst, data);
    if (stall) begin
      ci = cnt_inst;
      en = 1'b0; bus.inst_ready = 1'b1; pc_new = 32'h0000_0002;
      bus.imem_ack = 1'b1; bus.imem_data = 32'h5555_5555;
      repeat (2) begin
        @(posedge clk); #1;
        check32("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
        check32("stall_inst", bus.inst, data);
      end
      check32("stall_cnt_inst", cnt_inst, ci);
      bus.imem_ack = 1'b0; bus.imem_data = 32'hDEAD_BEEF;
      en = 1'b1;
    end
    bus.inst_ready = 1'b1; pc_new = npc; branched = br; is_jump = jmp; halt = hlt;
    @(posedge clk); #1;
    bus.inst_ready = 1'b0; pc_new = 32'hFFFF_FFFF; branched = 1'b1; is_jump = 1'b1; halt = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; en = 1'b0; halt = 1'b0; branched = 1'b0; is_jump = 1'b0; pc_new = 32'h0;
    en2 = 1'b0; halt2 = 1'b0; branched2 = 1'b0; is_jump2 = 1'b0; pc_new2 = 32'h0;
    bus.imem_ack = 1'b0; bus.imem_data = 32'h0; bus.inst_ready = 1'b0;
    bus2.imem_ack = 1'b0; bus2.imem_data = 32'h0; bus2.inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check32("rst_pc", pc, 32'h0000_0000);
    check32("rst_pc_4", pc_4, 32'h0000_0004);
    check32("rst_inst", bus.inst, 32'h0);
    check32("rst_flags", {27'd0, bus.inst_valid, bus.imem_req, halted, misalign, 1'b0}, 32'h0);
    check32("rst_cnt_cycle", cnt_cycle, 32'h0);
    check32("rst_cnt_inst", cnt_inst, 32'h0);

    // Back-to-back sequential fetches at minimum latency
    en = 1'b1;
    do_inst(32'h0000_0013, 32'h0000_0000, 0, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
    do_inst(32'h0010_0093, 32'h0000_0004, 0, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    do_inst(32'h0020_0113, 32'h0000_0008, 0, 1'b0, 1'b0, 32'h0000_000C, 1'b0, 1'b0, 1'b0);
    check32("seq_pc", pc, 32'h0000_000C);
    check32("seq_pc_4", pc_4, 32'h0000_0010);
    check32("seq_cnt_inst", cnt_inst, 32'd3);
    check32("seq_cnt_cycle", cnt_cycle, 32'd6);

    // Delayed ack with en toggled, then a taken branch
    do_inst(32'h0400_006F, 32'h0000_000C, 3, 1'b1, 1'b0, 32'h0000_0040, 1'b1, 1'b0, 1'b0);
    check32("br_pc", pc, 32'h0000_0040);
    check32("br_cnt_branch", cnt_branch, 32'd1);
    check32("br_cnt_jump", cnt_jump, 32'd0);

    // Jump with a HOLD stall (en low, stray ack ignored)
    do_inst(32'h0C00_006F, 32'h0000_0040, 1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b0);
    check32("jmp_pc", pc, 32'h0000_0100);
    check32("jmp_cnt_jump", cnt_jump, 32'd1);
    check32("jmp_cnt_branch", cnt_branch, 32'd1);
    check32("jmp_cnt_inst", cnt_inst, 32'd5);

    // Misaligned target together with halt
    do_inst(32'h0000_0073, 32'h0000_0100, 0, 1'b0, 1'b0, 32'h0000_0042, 1'b0, 1'b0, 1'b1);
    check32("mis_flag", {31'd0, misalign}, 32'd1);
    check32("mis_halted", {31'd0, halted}, 32'd1);
    check32("mis_pc", pc, 32'h0000_0100);
    check32("mis_cnt_inst", cnt_inst, 32'd6);
    repeat (4) begin
      @(posedge clk); #1;
      check32("halted_no_req", {30'd0, bus.imem_req, halted}, 32'd1);
    end

    // Asynchronous reset out of HALTED
    #3 rst_n = 1'b0;
    #2;
    check32("arst_halted", {30'd0, halted, misalign}, 32'd0);
    check32("arst_pc", pc, 32'h0000_0000);
    @(posedge clk); #1 rst_n = 1'b1;

    do_inst(32'h0000_0013, 32'h0000_0000, 0, 1'b0, 1'b0, 32'h0000_0020, 1'b0, 1'b0, 1'b0);
    // Fetch into HOLD without committing, then reset mid-HOLD
    n = 0;
    while (!bus.imem_req && n < 50) begin @(posedge clk); #1; n++; end
    check32("hold_addr", bus.imem_addr, 32'h0000_0020);
    bus.imem_ack = 1'b1; bus.imem_data = 32'h1111_1111;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    check32("hold_valid", {31'd0, bus.inst_valid}, 32'd1);
    check32("hold_cnt_inst", cnt_inst, 32'd1);
    #3 rst_n = 1'b0;
    #2;
    check32("hrst_flags", {30'd0, bus.inst_valid, bus.imem_req}, 32'd0);
    check32("hrst_pc", pc, 32'h0000_0000);
    check32("hrst_pc_4", pc_4, 32'h0000_0004);
    check32("hrst_inst", bus.inst, 32'h0);
    check32("hrst_cnt_inst", cnt_inst, 32'h0);
    check32("hrst_cnt_cycle", cnt_cycle, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    do_inst(32'h0000_0093, 32'h0000_0000, 0, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
    check32("post_rst_pc", pc, 32'h0000_0004);

    // Second instance: pc_4 wrap and 4-bit saturation
    check32("w_rst_pc", pc2, 32'hFFFF_FFFC);
    check32("w_rst_pc_4", pc_42, 32'h0000_0000);
    en2 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      n = 0;
      while (!bus2.imem_req && n < 50) begin @(posedge clk); #1; n++; end
      if (k == 0) check32("w_first_addr", bus2.imem_addr, 32'hFFFF_FFFC);
      bus2.imem_ack = 1'b1; bus2.imem_data = 32'h0000_0013;
      @(posedge clk); #1;
      bus2.imem_ack = 1'b0;
      n = 0;
      while (!bus2.inst_valid && n < 50) begin @(posedge clk); #1; n++; end
      bus2.inst_ready = 1'b1; pc_new2 = 32'h0000_0010; branched2 = 1'b1;
      @(posedge clk); #1;
      bus2.inst_ready = 1'b0; branched2 = 1'b0;
    end
    check32("sat_cnt_inst", {28'd0, cnt_inst2}, 32'd15);
    check32("sat_cnt_branch", {28'd0, cnt_branch2}, 32'd15);
    check32("sat_cnt_cycle", {28'd0, cnt_cycle2}, 32'd15);
    check32("sat_cnt_jump", {28'd0, cnt_jump2}, 32'd0);
    check32("sat_pc", pc2, 32'h0000_0010);

    check32("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
